// File: rtl/ethpipe_pkg.sv
// Shared Ethernet pipe definitions: FSM states, line bytes, slot header offsets.
package ethpipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WAIT,
    ST_PRE,
    ST_DATA,
    ST_IFG,
    ST_DONE
  } eth_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;

  // Slot word offsets; word 2 is reserved and never interpreted.
  localparam logic [10:0] WORD_TIME_LO = 11'd0;
  localparam logic [10:0] WORD_TIME_HI = 11'd1;
  localparam logic [10:0] WORD_LEN     = 11'd3;
  localparam logic [10:0] WORD_DATA    = 11'd4;

  // Byte n of a frame lives in lane n%4; lane 0 is bits 7:0.
  function automatic logic [7:0] lane_byte(input logic [31:0] w, input logic [1:0] lane);
    return w[8*lane +: 8];
  endfunction

endpackage

// File: rtl/ethpipe_tx_fetch.sv
// Holds the current slot data word and selects the byte lane being sent.
// Lane 0 is taken straight from RAM read data (the word arrives just in time),
// lanes 1..3 come from the copy captured alongside lane 0.
module ethpipe_tx_fetch
  import ethpipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] slot_q,
  input  logic        take,
  input  logic [1:0]  lane,
  output logic [7:0]  data_byte
);

  logic [31:0] word_q, word_d;

  // Capture the fresh word when its first lane is consumed; pick the output lane.
  always_comb begin
    word_d = word_q;
    if (take && (lane == 2'd0)) begin
      word_d = slot_q;
    end
    data_byte = (lane == 2'd0) ? slot_q[7:0] : lane_byte(word_q, lane);
  end

  // Word buffer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/ethpipe_tx.sv
// GMII transmitter: reads a frame from the TX slot RAM, waits for its launch
// time, then sends preamble, SFD and the stored frame bytes, followed by IFG.
module ethpipe_tx
  import ethpipe_pkg::*;
#(
  parameter int unsigned IFG_BYTES      = 12,
  parameter int unsigned PREAMBLE_BYTES = 7
) (
  input  logic        gmii_tx_clk,
  input  logic        sys_rst_n,
  input  logic [63:0] global_counter,
  output logic [10:0] slot_tx_eth_address,
  output logic        slot_tx_eth_rd_en,
  input  logic [31:0] slot_tx_eth_q,
  input  logic        tx_ready,
  output logic        tx_complete,
  output logic [7:0]  gmii_txd,
  output logic        gmii_tx_en
);

  localparam logic [10:0] PRE_CNT = 11'(PREAMBLE_BYTES);
  localparam logic [10:0] IFG_CNT = 11'(IFG_BYTES);

  eth_state_e  state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic [63:0] launch_q, launch_d;
  logic [10:0] len_q, len_d;
  logic [10:0] addr_q, addr_d;
  logic        rd_en_q, rd_en_d;
  logic        release_q, release_d;
  logic        done_q, done_d;
  logic [7:0]  txd_q, txd_d;
  logic        tx_en_q, tx_en_d;

  logic        take_byte;
  logic [1:0]  lane;
  logic [7:0]  fetch_byte;

  ethpipe_tx_fetch u_fetch (
    .clk       (gmii_tx_clk),
    .rst_n     (sys_rst_n),
    .slot_q    (slot_tx_eth_q),
    .take      (take_byte),
    .lane      (lane),
    .data_byte (fetch_byte)
  );

  // Next-state and registered-output computation for the transmit FSM.
  // cnt_q is shared: header cycle, preamble byte count, data byte count, IFG count.
  // Next data word is requested while lane 2 is sent so it lands exactly on lane 0.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    launch_d  = launch_q;
    len_d     = len_q;
    addr_d    = addr_q;
    rd_en_d   = 1'b0;
    release_d = release_q && tx_ready;
    done_d    = 1'b0;
    txd_d     = '0;
    tx_en_d   = 1'b0;
    take_byte = 1'b0;
    lane      = 2'd0;

    case (state_q)
      ST_IDLE: begin
        if (tx_ready && !release_q) begin
          state_d = ST_HDR;
          cnt_d   = '0;
          addr_d  = WORD_TIME_LO;
          rd_en_d = 1'b1;
        end
      end
      ST_HDR: begin
        cnt_d = cnt_q + 11'd1;
        if (cnt_q < WORD_LEN) begin
          addr_d  = cnt_q + 11'd1;
          rd_en_d = 1'b1;
        end
        if (cnt_q == WORD_TIME_LO + 11'd1) launch_d[31:0]  = slot_tx_eth_q;
        if (cnt_q == WORD_TIME_HI + 11'd1) launch_d[63:32] = slot_tx_eth_q;
        if (cnt_q == WORD_LEN + 11'd1) begin
          len_d = slot_tx_eth_q[26:16];
          if (slot_tx_eth_q[26:16] == '0) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (global_counter >= launch_q) begin
          state_d = ST_PRE;
          tx_en_d = 1'b1;
          txd_d   = PREAMBLE_BYTE;
          cnt_d   = 11'd1;
          addr_d  = WORD_DATA;
          rd_en_d = 1'b1;
        end
      end
      ST_PRE: begin
        tx_en_d = 1'b1;
        if (cnt_q <= PRE_CNT) begin
          txd_d   = (cnt_q == PRE_CNT) ? SFD_BYTE : PREAMBLE_BYTE;
          cnt_d   = cnt_q + 11'd1;
          rd_en_d = 1'b1;
        end else begin
          take_byte = 1'b1;
          txd_d     = fetch_byte;
          cnt_d     = 11'd1;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q < len_q) begin
          tx_en_d   = 1'b1;
          take_byte = 1'b1;
          lane      = cnt_q[1:0];
          txd_d     = fetch_byte;
          cnt_d     = cnt_q + 11'd1;
          if ((cnt_q[1:0] == 2'd2) && (({1'b0, cnt_q} + 12'd2) < {1'b0, len_q})) begin
            addr_d  = addr_q + 11'd1;
            rd_en_d = 1'b1;
          end
        end else if (IFG_CNT == '0) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_IFG;
          cnt_d   = 11'd1;
        end
      end
      ST_IFG: begin
        if (cnt_q < IFG_CNT) begin
          cnt_d = cnt_q + 11'd1;
        end else begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      ST_DONE: begin
        release_d = 1'b1;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge gmii_tx_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      launch_q  <= '0;
      len_q     <= '0;
      addr_q    <= '0;
      rd_en_q   <= 1'b0;
      release_q <= 1'b0;
      done_q    <= 1'b0;
      txd_q     <= '0;
      tx_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      launch_q  <= launch_d;
      len_q     <= len_d;
      addr_q    <= addr_d;
      rd_en_q   <= rd_en_d;
      release_q <= release_d;
      done_q    <= done_d;
      txd_q     <= txd_d;
      tx_en_q   <= tx_en_d;
    end
  end

  assign slot_tx_eth_address = addr_q;
  assign slot_tx_eth_rd_en   = rd_en_q;
  assign tx_complete         = done_q;
  assign gmii_txd            = txd_q;
  assign gmii_tx_en          = tx_en_q;

endmodule

// File: tb/tb_ethpipe_tx.sv
// Directed bench for ethpipe_tx with a behavioural slot RAM and GMII monitor.
module tb_ethpipe_tx;

  logic        clk;
  logic        sys_rst_n;
  logic [63:0] gc;
  logic [10:0] addr;
  logic        rd_en;
  logic [31:0] ram_q;
  logic        tx_ready;
  logic        tx_complete;
  logic [7:0]  gmii_txd;
  logic        gmii_tx_en;

  logic [31:0] mem [0:2047];

  int total;
  int bad;

  // monitor state
  logic [7:0]  rx_q[$];
  int          en_cycles;
  int          cmpl_cnt;
  int          cyc;
  int          last_en_cyc;
  int          cmpl_cyc;
  int          idle_bad;
  int          max_addr;
  logic [63:0] first_gc;
  logic [63:0] t;

  ethpipe_tx #(.IFG_BYTES(12), .PREAMBLE_BYTES(7)) dut (
    .gmii_tx_clk         (clk),
    .sys_rst_n           (sys_rst_n),
    .global_counter      (gc),
    .slot_tx_eth_address (addr),
    .slot_tx_eth_rd_en   (rd_en),
    .slot_tx_eth_q       (ram_q),
    .tx_ready            (tx_ready),
    .tx_complete         (tx_complete),
    .gmii_txd            (gmii_txd),
    .gmii_tx_en          (gmii_tx_en)
  );

  initial clk = 1'b0;
  always #4 clk = ~clk;

  initial gc = 64'd0;
  always @(posedge clk) gc <= gc + 64'd1;

  // synchronous-read slot RAM; output holds when not read
  initial ram_q = 32'd0;
  always @(posedge clk) if (rd_en) ram_q <= mem[addr];

  always @(negedge clk) begin
    cyc++;
    if (gmii_tx_en) begin
      if (en_cycles == 0) first_gc = gc;
      rx_q.push_back(gmii_txd);
      en_cycles++;
      last_en_cyc = cyc;
    end else if (gmii_txd != 8'h00) begin
      idle_bad++;
    end
    if (tx_complete) begin
      cmpl_cnt++;
      cmpl_cyc = cyc;
    end
    if (rd_en && (int'(addr) > max_addr)) max_addr = int'(addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 29 + 7) ^ (i >> 5));
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rx_q.delete();
    en_cycles   = 0;
    cmpl_cnt    = 0;
    last_en_cyc = 0;
    cmpl_cyc    = 0;
    idle_bad    = 0;
    max_addr    = 0;
    first_gc    = '0;
  endtask

  task automatic load_slot(input int len, input logic [63:0] tm);
    for (int w = 0; w < 2048; w++) mem[w] = 32'hEEEE_EEEE ^ 32'(w);
    mem[0] = tm[31:0];
    mem[1] = tm[63:32];
    mem[2] = 32'hDEAD_BEEF;
    mem[3] = {5'b10101, 11'(len), 16'h5A5A};
    for (int i = 0; i < len; i++) mem[4 + i / 4][8 * (i % 4) +: 8] = pat(i);
  endtask

  task automatic wait_cmpl(input int n, input int budget);
    int k;
    k = 0;
    while (cmpl_cnt < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk("cmpl_wait", 64'(cmpl_cnt), 64'(n));
  endtask

  task automatic check_frame(input int len, input int addr_exp);
    int errs;
    logic [7:0] e;
    errs = 0;
    chk("en_cycles", 64'(en_cycles), 64'(len + 8));
    for (int i = 0; i < 8 && i < rx_q.size(); i++) begin
      e = (i == 7) ? 8'hD5 : 8'h55;
      if (rx_q[i] !== e) errs++;
    end
    chk("pre_sfd_err", 64'(errs), 64'd0);
    errs = 0;
    for (int i = 0; i < len && (8 + i) < rx_q.size(); i++) begin
      if (rx_q[8 + i] !== pat(i)) errs++;
    end
    chk("payload_err", 64'(errs), 64'd0);
    chk("max_addr", 64'(max_addr), 64'(addr_exp));
    chk("ifg_gap", 64'(cmpl_cyc - last_en_cyc), 64'd13);
    chk("idle_bus", 64'(idle_bad), 64'd0);
  endtask

  initial begin
    int k;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    sys_rst_n = 1'b0;
    tx_ready  = 1'b0;
    clear_mon();
    load_slot(60, 64'd0);

    // reset state
    tick(3);
    chk("rst_tx_en", 64'(gmii_tx_en), 64'd0);
    chk("rst_txd", 64'(gmii_txd), 64'd0);
    chk("rst_cmpl", 64'(tx_complete), 64'd0);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    sys_rst_n = 1'b1;
    tick(3);
    chk("idle_no_read", 64'(rd_en), 64'd0);

    // 60-byte frame, immediate launch
    clear_mon();
    tx_ready = 1'b1;
    wait_cmpl(1, 400);
    check_frame(60, 18);
    // tx_ready kept high: no second frame
    tick(40);
    chk("no_resend_cmpl", 64'(cmpl_cnt), 64'd1);
    chk("no_resend_en", 64'(en_cycles), 64'd68);
    // drop and re-raise: slot sent again
    tx_ready = 1'b0;
    tick(2);
    tx_ready = 1'b1;
    wait_cmpl(2, 400);
    tx_ready = 1'b0;
    chk("resend_en", 64'(en_cycles), 64'd136);
    tick(4);

    // delayed launch
    t = gc + 64'd100;
    load_slot(60, t);
    clear_mon();
    tx_ready = 1'b1;
    wait_cmpl(1, 600);
    tx_ready = 1'b0;
    chk("launch_gc", first_gc, t + 64'd1);
    chk("launch_en", 64'(en_cycles), 64'd68);
    tick(4);

    // zero length
    load_slot(0, 64'd0);
    clear_mon();
    tx_ready = 1'b1;
    wait_cmpl(1, 100);
    tick(10);
    tx_ready = 1'b0;
    chk("l0_en", 64'(en_cycles), 64'd0);
    chk("l0_cmpl", 64'(cmpl_cnt), 64'd1);
    chk("l0_max_addr", 64'(max_addr), 64'd3);
    tick(4);

    // partial last word
    load_slot(61, 64'd5);
    clear_mon();
    tx_ready = 1'b1;
    wait_cmpl(1, 400);
    tx_ready = 1'b0;
    check_frame(61, 19);
    tick(4);

    // maximum length
    load_slot(2047, 64'd0);
    clear_mon();
    tx_ready = 1'b1;
    wait_cmpl(1, 3000);
    tx_ready = 1'b0;
    check_frame(2047, 515);
    tick(4);

    // reset in the middle of a 64-byte frame
    load_slot(64, 64'd0);
    clear_mon();
    tx_ready = 1'b1;
    k = 0;
    while (rx_q.size() < 39 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("reach_byte30", 64'(rx_q.size() >= 39), 64'd1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort_tx_en", 64'(gmii_tx_en), 64'd0);
    chk("abort_txd", 64'(gmii_txd), 64'd0);
    tick(3);
    chk("abort_no_cmpl", 64'(cmpl_cnt), 64'd0);
    sys_rst_n = 1'b1;
    clear_mon();
    wait_cmpl(1, 400);
    tx_ready = 1'b0;
    check_frame(64, 19);
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ethpipe_tx.md
ETHPIPE_TX -- requirements
Module: ethpipe_tx

Interface
REQ-001 Parameter IFG_BYTES, default 12, idle gmii_tx_clk cycles enforced after each frame.
REQ-002 Parameter PREAMBLE_BYTES, default 7, count of 0x55 bytes sent before SFD 0xD5.
REQ-003 gmii_tx_clk  in  1  sole clock; all logic on rising edge.
REQ-004 sys_rst_n  in  1  asynchronous, active-low reset.
REQ-005 global_counter  in  64  free-running timestamp, gmii_tx_clk domain.
REQ-006 slot_tx_eth_address  out  11  TX slot RAM word address.
REQ-007 slot_tx_eth_rd_en  out  1  TX slot RAM read strobe.
REQ-008 slot_tx_eth_q  in  32  RAM read data, valid the cycle after address/rd_en are registered.
REQ-009 tx_ready  in  1  level; slot holds a frame (already synchronised into gmii_tx_clk).
REQ-010 tx_complete  out  1  one-cycle pulse, slot consumed.
REQ-011 gmii_txd  out  8  GMII transmit data.
REQ-012 gmii_tx_en  out  1  GMII transmit enable.

Function
REQ-013 Slot layout: word0 = launch time[31:0], word1 = launch time[63:32], word2 = reserved (ignored), word3[26:16] = frame length L in bytes (DA through FCS inclusive), frame bytes from word4, byte n at word 4+n/4, lane n%4 (lane 0 = bits 7:0).
REQ-014 FSM states: IDLE, HDR, WAIT, PRE, DATA, IFG, DONE.
REQ-015 IDLE -> HDR when tx_ready=1 and release flag clear; HDR reads words 0..3 back-to-back, latching time and L.
REQ-016 HDR -> DONE if L=0 (nothing transmitted); otherwise -> WAIT.
REQ-017 WAIT -> PRE on first cycle with global_counter >= launch time (unsigned 64-bit compare); launch time 0 departs on the first WAIT cycle.
REQ-018 PRE drives gmii_tx_en=1 for PREAMBLE_BYTES cycles of 0x55 then one cycle of 0xD5.
REQ-019 DATA drives exactly L bytes, consecutive cycles, gmii_tx_en=1, no bubbles; word4 prefetch issued during PRE so first frame byte directly follows SFD.
REQ-020 FCS is taken from the slot unmodified; no CRC generation or padding.
REQ-021 IFG holds gmii_tx_en=0, gmii_txd=0 for IFG_BYTES cycles, then -> DONE.
REQ-022 DONE pulses tx_complete for one cycle, sets release flag, -> IDLE.
REQ-023 Release flag clears when tx_ready=0; prevents resending a slot whose tx_ready has not yet dropped.
REQ-024 Outside PRE/DATA gmii_tx_en=0 and gmii_txd=8'h00.
REQ-025 Byte counter 11 bits; L up to 2047 supported; read address never exceeds 4+(L-1)/4.
REQ-026 tx_ready falling mid-frame is ignored; frame completes.
REQ-027 gmii_txd/gmii_tx_en are registered outputs; total latency from WAIT exit to first 0x55 is one cycle.

Reset
REQ-028 sys_rst_n low: FSM to IDLE, gmii_tx_en=0, gmii_txd=0, tx_complete=0, slot_tx_eth_rd_en=0, slot_tx_eth_address=0, release flag clear, latched time/L cleared.
REQ-029 Reset mid-frame drops gmii_tx_en asynchronously; no tx_complete for the aborted frame; slot resent after reset if tx_ready still high.

Structure
REQ-030 FSM state encodings, preamble/SFD bytes and header word offsets (0..4) reside in shared package ethpipe_pkg, also used by the receiver.
REQ-031 Sub-module ethpipe_tx_fetch (RAM address/prefetch and byte-lane selection) is permitted; FSM stays in ethpipe_tx.

Verification
REQ-032 L=60, time=0, tx_ready=1 -> 7x0x55, 0xD5, 60 slot bytes in lane order, tx_en high 68 cycles, 12 idle, one tx_complete.
REQ-033 time=global_counter+100 -> first 0x55 appears in cycle where global_counter = time+1, not earlier.
REQ-034 L=0 -> tx_en never asserts, tx_complete pulses once.
REQ-035 tx_ready held high after tx_complete -> no second frame until tx_ready low then high.
REQ-036 sys_rst_n asserted at byte 30 of 64-byte frame -> tx_en=0 immediately, no tx_complete; after release full frame resent.
REQ-037 L=61 and L=2047 -> last word partially used, correct byte count, address stops at 19 / 515.
